mole_round_scheduler: RTL and testbench

Sequences the mole up/down timing for a game. It replaces the fixed MOLE_UP_MS/MOLE_DOWN_MS cadence with a scheduler that issues the mole_clk pulse to the mole generator and gates mole visibility. It ends an up-phase early when the player clears all moles, and shortens the up-phase as the player levels up. It sits between the game FSM and timer (game_active, ms_tick) and the mole generator and hit logic.

---
 rtl/mole_round_scheduler_if.sv | 25 ++
 rtl/mole_round_scheduler.sv | 132 +++++++++++++
 tb/tb_mole_round_scheduler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_round_scheduler_if.sv
// Mole round scheduler bus.
// Groups the timing, game-event and mole-control signals that run between the
// game FSM/timer, the round scheduler, and the mole generator/hit logic.
//   master : environment side (drives ms_tick, game_active, full_clear_hit, miss)
//   slave  : scheduler side   (drives mole_clk, moles_visible, level, up_ms)
interface mole_round_scheduler_if;
   logic        ms_tick;
   logic        game_active;
   logic        full_clear_hit;
   logic        miss;
   logic        mole_clk;
   logic        moles_visible;
   logic [2:0]  level;
   logic [15:0] up_ms;

   modport master (
      output ms_tick, game_active, full_clear_hit, miss,
      input  mole_clk, moles_visible, level, up_ms
   );

   modport slave (
      input  ms_tick, game_active, full_clear_hit, miss,
      output mole_clk, moles_visible, level, up_ms
   );
endinterface

// File: rtl/mole_round_scheduler.sv
// Mole round scheduler.
// Alternates a down-phase (moles hidden) and an up-phase (moles visible),
// pulsing mole_clk at each up-phase entry so the generator loads a new set.
// An up-phase ends early on a full clear; every CLEARS_PER_LEVEL consecutive
// clears raise the level and shorten the up-phase, down to UP_MS_MIN.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of mole_round_scheduler_if
//          in : ms_tick, game_active, full_clear_hit, miss
//          out: mole_clk, moles_visible, level, up_ms (all registered)
module mole_round_scheduler #(
   parameter int unsigned UP_MS_INIT       = 1000,
   parameter int unsigned DOWN_MS          = 1000,
   parameter int unsigned UP_MS_STEP       = 100,
   parameter int unsigned UP_MS_MIN        = 300,
   parameter int unsigned CLEARS_PER_LEVEL = 4,
   parameter int unsigned MAX_LEVEL        = 7
) (
   input logic                  clk,
   input logic                  rst,
   mole_round_scheduler_if.slave bus
);

   localparam int unsigned CW           = $clog2(CLEARS_PER_LEVEL + 1);
   localparam logic [CW-1:0] CLEAR_GOAL = CW'(CLEARS_PER_LEVEL);
   localparam logic [2:0]  LEVEL_TOP    = 3'(MAX_LEVEL);
   localparam logic [15:0] UP_INIT      = 16'(UP_MS_INIT);
   localparam logic [15:0] DOWN_LEN     = 16'(DOWN_MS);
   localparam logic [15:0] UP_STEP      = 16'(UP_MS_STEP);
   localparam logic [15:0] UP_FLOOR     = 16'(UP_MS_MIN);
   // Smallest up_ms that can take a full step without dropping below the floor.
   localparam logic [16:0] SHRINK_MIN   = 17'(UP_MS_MIN + UP_MS_STEP);

   typedef enum logic [1:0] {StIdle, StDown, StUp} state_e;

   state_e        state_q;
   logic [15:0]   cnt_q;
   logic [CW-1:0] clear_count_q;
   logic          mole_clk_q;
   logic          moles_visible_q;
   logic [2:0]    level_q;
   logic [15:0]   up_ms_q;

   logic [CW-1:0] clear_inc;
   logic [15:0]   up_ms_shrunk;
   logic          phase_done;

   always_comb begin
      clear_inc    = clear_count_q + 1'b1;
      // Compare before subtracting so up_ms never underflows.
      up_ms_shrunk = ({1'b0, up_ms_q} >= SHRINK_MIN) ? (up_ms_q - UP_STEP) : UP_FLOOR;
      phase_done   = bus.ms_tick && (cnt_q <= 16'd1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= StIdle;
         cnt_q           <= '0;
         clear_count_q   <= '0;
         mole_clk_q      <= 1'b0;
         moles_visible_q <= 1'b0;
         level_q         <= '0;
         up_ms_q         <= UP_INIT;
      end else begin
         mole_clk_q <= 1'b0;
         if (!bus.game_active) begin
            // level and up_ms stay readable until the next game start.
            state_q         <= StIdle;
            moles_visible_q <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  state_q       <= StDown;
                  cnt_q         <= DOWN_LEN;
                  level_q       <= '0;
                  up_ms_q       <= UP_INIT;
                  clear_count_q <= '0;
               end
               StDown: begin
                  if (phase_done) begin
                     state_q         <= StUp;
                     cnt_q           <= up_ms_q;
                     mole_clk_q      <= 1'b1;
                     moles_visible_q <= 1'b1;
                  end else if (bus.ms_tick) begin
                     cnt_q <= cnt_q - 16'd1;
                  end
               end
               StUp: begin
                  if (bus.full_clear_hit) begin
                     // A clear wins over a coincident timeout tick or miss.
                     state_q         <= StDown;
                     cnt_q           <= DOWN_LEN;
                     moles_visible_q <= 1'b0;
                     if (clear_inc == CLEAR_GOAL) begin
                        clear_count_q <= '0;
                        if (level_q < LEVEL_TOP) begin
                           level_q <= level_q + 3'd1;
                           up_ms_q <= up_ms_shrunk;
                        end
                     end else begin
                        clear_count_q <= clear_inc;
                     end
                  end else begin
                     if (bus.miss) begin
                        clear_count_q <= '0;
                     end
                     if (phase_done) begin
                        state_q         <= StDown;
                        cnt_q           <= DOWN_LEN;
                        moles_visible_q <= 1'b0;
                        clear_count_q   <= '0;
                     end else if (bus.ms_tick) begin
                        cnt_q <= cnt_q - 16'd1;
                     end
                  end
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign bus.mole_clk      = mole_clk_q;
   assign bus.moles_visible = moles_visible_q;
   assign bus.level         = level_q;
   assign bus.up_ms         = up_ms_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Self-checking bench for mole_round_scheduler.
// The driver pushes one expectation per moles_visible transition (direction,
// ms_ticks spent in the finished phase, level and up_ms after the edge); a
// negedge monitor pops and compares them as the transitions appear.
module tb_mole_round_scheduler;

   logic clk;
   logic rst;

   mole_round_scheduler_if bus ();

   mole_round_scheduler #(
      .UP_MS_INIT       (10),
      .DOWN_MS          (5),
      .UP_MS_STEP       (3),
      .UP_MS_MIN        (4),
      .CLEARS_PER_LEVEL (2),
      .MAX_LEVEL        (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        rise;
      int          ticks;   // -1: duration not checked
      logic [2:0]  lvl;
      logic [15:0] ups;
   } edge_t;

   edge_t sb[$];
   int    total = 0;
   int    bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
      end
   endtask

   task automatic sb_push(input string tag, input logic rise, input int n,
                          input logic [2:0] l, input logic [15:0] u);
      edge_t e;
      e.tag = tag; e.rise = rise; e.ticks = n; e.lvl = l; e.ups = u;
      sb.push_back(e);
   endtask

   // One clock of stimulus; pulses are cleared afterwards.
   task automatic cyc(input logic t, input logic h, input logic m);
      bus.ms_tick        = t;
      bus.full_clear_hit = h;
      bus.miss           = m;
      @(posedge clk);
      #1;
      bus.ms_tick        = 1'b0;
      bus.full_clear_hit = 1'b0;
      bus.miss           = 1'b0;
   endtask

   // n ms_ticks, one every 4 clocks.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         repeat (3) cyc(1'b0, 1'b0, 1'b0);
      end
   endtask

   // Full down-phase, then a clear after k ticks of the up-phase.
   task automatic clear_round(input int k, input logic [2:0] lb, input logic [15:0] ub,
                              input logic [2:0] la, input logic [15:0] ua);
      sb_push("rise", 1'b1, 5, lb, ub);
      ticks(5);
      sb_push("clear", 1'b0, k, la, ua);
      ticks(k);
      cyc(1'b0, 1'b1, 1'b0);
   endtask

   task automatic timeout_round(input logic [2:0] l, input logic [15:0] u);
      sb_push("rise", 1'b1, 5, l, u);
      sb_push("timeout", 1'b0, int'(u), l, u);
      ticks(5 + int'(u));
   endtask

   // Monitor: outputs sampled on the falling edge.
   initial begin
      logic  prev_vis;
      logic  prev_ga;
      int    tick_cnt;
      edge_t e;
      prev_vis = 1'b0;
      prev_ga  = 1'b0;
      tick_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_vis = 1'b0;
            prev_ga  = 1'b0;
            tick_cnt = 0;
         end else begin
            check("mole_clk_on_rise", 32'(bus.mole_clk), 32'(bus.moles_visible && !prev_vis));
            if (bus.moles_visible !== prev_vis) begin
               if (sb.size() == 0) begin
                  check("sb_underflow", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check({e.tag, "_dir"}, 32'(bus.moles_visible), 32'(e.rise));
                  if (e.ticks >= 0) check({e.tag, "_ticks"}, 32'(tick_cnt), 32'(e.ticks));
                  check({e.tag, "_level"}, 32'(bus.level), 32'(e.lvl));
                  check({e.tag, "_up_ms"}, 32'(bus.up_ms), 32'(e.ups));
               end
               tick_cnt = 0;
            end
            prev_vis = bus.moles_visible;
            // Ticks in the cycle that starts a game are consumed by IDLE.
            if (bus.game_active && prev_ga && bus.ms_tick) tick_cnt++;
            if (!bus.game_active) tick_cnt = 0;
            prev_ga = bus.game_active;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                = 1'b1;
      bus.game_active    = 1'b0;
      bus.ms_tick        = 1'b0;
      bus.full_clear_hit = 1'b0;
      bus.miss           = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mole_clk", 32'(bus.mole_clk), 32'd0);
      check("rst_visible", 32'(bus.moles_visible), 32'd0);
      check("rst_level", 32'(bus.level), 32'd0);
      check("rst_up_ms", 32'(bus.up_ms), 32'd10);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      // Idle ticks are ignored.
      ticks(3);
      check("idle_visible", 32'(bus.moles_visible), 32'd0);

      // 1: free-running cadence.
      bus.game_active = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      timeout_round(3'd0, 16'd10);
      timeout_round(3'd0, 16'd10);

      // 2: two clears on tick 3 -> level 1, up_ms 7, next up-phase 7 ticks.
      clear_round(3, 3'd0, 16'd10, 3'd0, 16'd10);
      clear_round(3, 3'd0, 16'd10, 3'd1, 16'd7);
      timeout_round(3'd1, 16'd7);

      // 3: climb to saturation; up_ms 7 -> 4 -> 4, wrap at MAX_LEVEL holds.
      clear_round(2, 3'd1, 16'd7, 3'd1, 16'd7);
      clear_round(2, 3'd1, 16'd7, 3'd2, 16'd4);
      clear_round(2, 3'd2, 16'd4, 3'd2, 16'd4);
      clear_round(2, 3'd2, 16'd4, 3'd3, 16'd4);
      clear_round(2, 3'd3, 16'd4, 3'd3, 16'd4);
      clear_round(2, 3'd3, 16'd4, 3'd3, 16'd4);
      timeout_round(3'd3, 16'd4);

      // End game in DOWN: level/up_ms held; restart re-initialises them.
      bus.game_active = 1'b0;
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      check("held_level", 32'(bus.level), 32'd3);
      check("held_up_ms", 32'(bus.up_ms), 32'd4);
      bus.game_active = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      check("restart_level", 32'(bus.level), 32'd0);
      check("restart_up_ms", 32'(bus.up_ms), 32'd10);

      // 4: clear, miss, clear -> level 0; clear, timeout, clear -> level 0.
      clear_round(2, 3'd0, 16'd10, 3'd0, 16'd10);
      sb_push("rise", 1'b1, 5, 3'd0, 16'd10);
      ticks(5);
      ticks(1);
      cyc(1'b0, 1'b0, 1'b1);
      ticks(1);
      sb_push("clear_after_miss", 1'b0, 2, 3'd0, 16'd10);
      cyc(1'b0, 1'b1, 1'b0);
      timeout_round(3'd0, 16'd10);
      clear_round(2, 3'd0, 16'd10, 3'd0, 16'd10);
      timeout_round(3'd0, 16'd10);

      // 5: clear on the timeout tick, then clear together with miss -> level 1.
      sb_push("rise", 1'b1, 5, 3'd0, 16'd10);
      ticks(5);
      sb_push("clear_on_timeout", 1'b0, 10, 3'd0, 16'd10);
      ticks(9);
      cyc(1'b1, 1'b1, 1'b0);
      sb_push("rise", 1'b1, 5, 3'd0, 16'd10);
      ticks(5);
      sb_push("clear_with_miss", 1'b0, 2, 3'd1, 16'd7);
      ticks(2);
      cyc(1'b0, 1'b1, 1'b1);

      // 6a: drop game_active mid-UP.
      sb_push("rise", 1'b1, 5, 3'd1, 16'd7);
      ticks(5);
      ticks(2);
      sb_push("drop", 1'b0, -1, 3'd1, 16'd7);
      bus.game_active = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      check("drop_visible", 32'(bus.moles_visible), 32'd0);
      check("drop_mole_clk", 32'(bus.mole_clk), 32'd0);
      repeat (4) cyc(1'b1, 1'b0, 1'b0);
      check("drop_level_held", 32'(bus.level), 32'd1);
      check("drop_up_ms_held", 32'(bus.up_ms), 32'd7);

      // 6b: async reset mid-DOWN at level 1.
      bus.game_active = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      clear_round(2, 3'd0, 16'd10, 3'd0, 16'd10);
      clear_round(2, 3'd0, 16'd10, 3'd1, 16'd7);
      ticks(2);
      check("pre_rst_level", 32'(bus.level), 32'd1);
      #2;
      rst             = 1'b1;
      bus.game_active = 1'b0;
      #1;
      check("arst_mole_clk", 32'(bus.mole_clk), 32'd0);
      check("arst_visible", 32'(bus.moles_visible), 32'd0);
      check("arst_level", 32'(bus.level), 32'd0);
      check("arst_up_ms", 32'(bus.up_ms), 32'd10);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      check("post_rst_visible", 32'(bus.moles_visible), 32'd0);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
